// File: rtl/decode_pkg.sv
// Decode stage package: RV32I opcodes, ALU control codes, immediate formats,
// decoded-field bundle and the immediate generator shared by the decode logic.
package decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ALU_W   = 6;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [ALU_W-1:0] ALU_CTRL_NONE = 6'd0;
    localparam logic [ALU_W-1:0] ALU_CTRL_ADD  = 6'd1;
    localparam logic [ALU_W-1:0] ALU_CTRL_SUB  = 6'd2;
    localparam logic [ALU_W-1:0] ALU_CTRL_SLL  = 6'd3;
    localparam logic [ALU_W-1:0] ALU_CTRL_SLT  = 6'd4;
    localparam logic [ALU_W-1:0] ALU_CTRL_SLTU = 6'd5;
    localparam logic [ALU_W-1:0] ALU_CTRL_XOR  = 6'd6;
    localparam logic [ALU_W-1:0] ALU_CTRL_SRL  = 6'd7;
    localparam logic [ALU_W-1:0] ALU_CTRL_SRA  = 6'd8;
    localparam logic [ALU_W-1:0] ALU_CTRL_OR   = 6'd9;
    localparam logic [ALU_W-1:0] ALU_CTRL_AND  = 6'd10;
    localparam logic [ALU_W-1:0] ALU_CTRL_BEQ  = 6'd11;
    localparam logic [ALU_W-1:0] ALU_CTRL_BNE  = 6'd12;
    localparam logic [ALU_W-1:0] ALU_CTRL_BLT  = 6'd13;
    localparam logic [ALU_W-1:0] ALU_CTRL_BGE  = 6'd14;
    localparam logic [ALU_W-1:0] ALU_CTRL_LUI  = 6'd15;
    localparam logic [ALU_W-1:0] ALU_CTRL_JAL  = 6'd16;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [ALU_W-1:0] alu_ctrl;
        imm_type_e        imm_type;
        logic             is_wb;
        logic             is_load;
        logic             is_store;
        logic             is_imm;
        logic             is_branch;
        logic             is_jump;
        logic             illegal;
        logic             uses_rs1;
        logic             uses_rs2;
    } dec_fields_t;

    // 32-bit sign-extended immediate for the given instruction format
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_p.sv
// Two-read/one-write register file, x0 hard-wired to zero, write-first bypass.
// Ports: clock, reset_n, we/wsel/wdata (write port), rsel1/rsel2 (read selects),
//        rdata1_c/rdata2_c (combinational read data including same-cycle write).
module regfile_p #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned RSEL_W = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [RSEL_W-1:0] wsel,
    input  logic [XLEN-1:0]   wdata,
    input  logic [RSEL_W-1:0] rsel1,
    input  logic [RSEL_W-1:0] rsel2,
    output logic [XLEN-1:0]   rdata1_c,
    output logic [XLEN-1:0]   rdata2_c
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;

    assign wr_en = we && (wsel != '0);

    // Storage; writes to x0 are dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wsel] <= wdata;
        end
    end

    // Reads: x0 is zero, a same-cycle write to the selected register wins
    always_comb begin
        rdata1_c = regs[rsel1];
        rdata2_c = regs[rsel2];
        if (rsel1 == '0)                     rdata1_c = '0;
        else if (wr_en && (wsel == rsel1))   rdata1_c = wdata;
        if (rsel2 == '0)                     rdata2_c = '0;
        else if (wr_en && (wsel == rsel2))   rdata2_c = wdata;
    end

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage: RV32I-subset decoder, register read with WB bypass, load-use
// interlock, branch flush and the D/A pipeline register.
// Ports: clock/reset_n; fd_* fetch beat in, d_ready (combinational) back to fetch;
//        *_regfile writeback port; flush; a_ready from execute; da_* D/A register
//        contents; bubble_count saturating count of load-use bubbles.
module decode_hazard_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned RSEL_W = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fd_valid,
    input  logic [PC_W-1:0]   fd_pc,
    input  logic [31:0]       fd_instr,
    output logic              d_ready,
    input  logic              w_regfile,
    input  logic [RSEL_W-1:0] sel_regfile,
    input  logic [XLEN-1:0]   data_regfile,
    input  logic              flush,
    input  logic              a_ready,
    output logic              da_valid,
    output logic [PC_W-1:0]   da_pc,
    output logic [RSEL_W-1:0] da_read_sel1,
    output logic [RSEL_W-1:0] da_read_sel2,
    output logic [RSEL_W-1:0] da_write_sel,
    output logic [XLEN-1:0]   da_data1,
    output logic [XLEN-1:0]   da_data2,
    output logic [XLEN-1:0]   da_imm32,
    output logic [5:0]        da_alu_ctrl,
    output logic [PC_W-1:0]   da_target_pc,
    output logic              da_is_wb,
    output logic              da_is_load,
    output logic              da_is_store,
    output logic              da_is_imm,
    output logic              da_is_branch,
    output logic              da_is_jump,
    output logic              da_illegal,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd_raw;
    logic [RSEL_W-1:0] rs1;
    logic [RSEL_W-1:0] rs2;
    logic [RSEL_W-1:0] rd;
    dec_fields_t       dec;
    logic              bad;
    logic [31:0]       imm_raw;
    logic [XLEN-1:0]   imm_x;
    logic [PC_W-1:0]   target_c;
    logic [XLEN-1:0]   rdata1_c;
    logic [XLEN-1:0]   rdata2_c;
    logic              hazard_c;
    logic              stall_c;

    assign opcode = fd_instr[6:0];
    assign funct3 = fd_instr[14:12];
    assign funct7 = fd_instr[31:25];
    assign rd_raw = fd_instr[11:7];
    assign rs1    = RSEL_W'(fd_instr[19:15]);
    assign rs2    = RSEL_W'(fd_instr[24:20]);
    assign rd     = RSEL_W'(rd_raw);

    regfile_p #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .we       (w_regfile),
        .wsel     (sel_regfile),
        .wdata    (data_regfile),
        .rsel1    (rs1),
        .rsel2    (rs2),
        .rdata1_c (rdata1_c),
        .rdata2_c (rdata2_c)
    );

    // Instruction decoder; any unsupported encoding collapses to a bare illegal flag
    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opcode)
            OPC_R: begin
                dec.is_wb    = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec.alu_ctrl = ALU_CTRL_ADD;
                    {7'h20, 3'b000}: dec.alu_ctrl = ALU_CTRL_SUB;
                    {7'h00, 3'b001}: dec.alu_ctrl = ALU_CTRL_SLL;
                    {7'h00, 3'b010}: dec.alu_ctrl = ALU_CTRL_SLT;
                    {7'h00, 3'b011}: dec.alu_ctrl = ALU_CTRL_SLTU;
                    {7'h00, 3'b100}: dec.alu_ctrl = ALU_CTRL_XOR;
                    {7'h00, 3'b101}: dec.alu_ctrl = ALU_CTRL_SRL;
                    {7'h20, 3'b101}: dec.alu_ctrl = ALU_CTRL_SRA;
                    {7'h00, 3'b110}: dec.alu_ctrl = ALU_CTRL_OR;
                    {7'h00, 3'b111}: dec.alu_ctrl = ALU_CTRL_AND;
                    default:         bad = 1'b1;
                endcase
            end
            OPC_I_ALU: begin
                dec.is_wb    = 1'b1;
                dec.is_imm   = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.imm_type = IMM_I;
                case (funct3)
                    3'b000: dec.alu_ctrl = ALU_CTRL_ADD;
                    3'b010: dec.alu_ctrl = ALU_CTRL_SLT;
                    3'b011: dec.alu_ctrl = ALU_CTRL_SLTU;
                    3'b100: dec.alu_ctrl = ALU_CTRL_XOR;
                    3'b110: dec.alu_ctrl = ALU_CTRL_OR;
                    3'b111: dec.alu_ctrl = ALU_CTRL_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_CTRL_SLL;
                        bad          = (funct7 != 7'h00);
                    end
                    default: begin
                        // 3'b101: shift-right family selected by funct7
                        if (funct7 == 7'h00)      dec.alu_ctrl = ALU_CTRL_SRL;
                        else if (funct7 == 7'h20) dec.alu_ctrl = ALU_CTRL_SRA;
                        else                      bad = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                dec.is_wb    = 1'b1;
                dec.is_load  = 1'b1;
                dec.is_imm   = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.imm_type = IMM_I;
                dec.alu_ctrl = ALU_CTRL_ADD;
                bad = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                dec.is_store = 1'b1;
                dec.is_imm   = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.imm_type = IMM_S;
                dec.alu_ctrl = ALU_CTRL_ADD;
                bad = !(funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
                dec.imm_type  = IMM_B;
                case (funct3)
                    3'b000:  dec.alu_ctrl = ALU_CTRL_BEQ;
                    3'b001:  dec.alu_ctrl = ALU_CTRL_BNE;
                    3'b100:  dec.alu_ctrl = ALU_CTRL_BLT;
                    3'b101:  dec.alu_ctrl = ALU_CTRL_BGE;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.is_wb    = 1'b1;
                dec.is_imm   = 1'b1;
                dec.imm_type = IMM_U;
                dec.alu_ctrl = ALU_CTRL_LUI;
            end
            OPC_JAL: begin
                dec.is_wb    = 1'b1;
                dec.is_jump  = 1'b1;
                dec.imm_type = IMM_J;
                dec.alu_ctrl = ALU_CTRL_JAL;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        if (rd_raw == 5'd0) begin
            dec.is_wb = 1'b0;
        end
    end

    assign imm_raw  = imm_gen(fd_instr, dec.imm_type);
    assign imm_x    = XLEN'($signed(imm_raw));
    assign target_c = fd_pc + PC_W'($signed(imm_raw));

    // Load-use interlock against the instruction currently held in D/A
    assign hazard_c = da_valid && da_is_load && (da_write_sel != '0) &&
                      ((dec.uses_rs1 && (rs1 == da_write_sel)) ||
                       (dec.uses_rs2 && (rs2 == da_write_sel)));
    assign stall_c  = da_valid && !a_ready;
    assign d_ready  = flush || (!hazard_c && (!da_valid || a_ready));

    // D/A pipeline register and bubble counter; priority flush > stall > hazard > load > drain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            da_valid     <= 1'b0;
            da_pc        <= '0;
            da_read_sel1 <= '0;
            da_read_sel2 <= '0;
            da_write_sel <= '0;
            da_data1     <= '0;
            da_data2     <= '0;
            da_imm32     <= '0;
            da_alu_ctrl  <= '0;
            da_target_pc <= '0;
            da_is_wb     <= 1'b0;
            da_is_load   <= 1'b0;
            da_is_store  <= 1'b0;
            da_is_imm    <= 1'b0;
            da_is_branch <= 1'b0;
            da_is_jump   <= 1'b0;
            da_illegal   <= 1'b0;
            bubble_count <= '0;
        end else if (flush) begin
            da_valid <= 1'b0;
        end else if (stall_c) begin
            // Held operands track writebacks that land while execute is stalled
            if (w_regfile && (sel_regfile != '0) && (sel_regfile == da_read_sel1)) begin
                da_data1 <= data_regfile;
            end
            if (w_regfile && (sel_regfile != '0) && (sel_regfile == da_read_sel2)) begin
                da_data2 <= data_regfile;
            end
        end else if (hazard_c) begin
            da_valid <= 1'b0;
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end else if (fd_valid) begin
            da_valid     <= 1'b1;
            da_pc        <= fd_pc;
            da_read_sel1 <= rs1;
            da_read_sel2 <= rs2;
            da_write_sel <= rd;
            da_data1     <= rdata1_c;
            da_data2     <= rdata2_c;
            da_imm32     <= imm_x;
            da_alu_ctrl  <= dec.alu_ctrl;
            da_target_pc <= target_c;
            da_is_wb     <= dec.is_wb;
            da_is_load   <= dec.is_load;
            da_is_store  <= dec.is_store;
            da_is_imm    <= dec.is_imm;
            da_is_branch <= dec.is_branch;
            da_is_jump   <= dec.is_jump;
            da_illegal   <= dec.illegal;
        end else begin
            da_valid <= 1'b0;
        end
    end

endmodule
